// File: rtl/uart_cmd_rx_if.sv
// Output bundle of the UART command receiver: received bytes, decoded
// commands and line status.
interface uart_cmd_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [9:0] cmd_value;
  logic       cmd_valid;
  logic       cmd_err;
  logic       busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output cmd_value,
    output cmd_valid,
    output cmd_err,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input cmd_value,
    input cmd_valid,
    input cmd_err,
    input busy
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver with a line decoder that turns "ddd\n" / "ddd\r\n"
// commands into a binary value (0..999).
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 625,
  parameter int MAX_DIGITS   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_cmd_rx_if.master bus
);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int DIG_W = $clog2(MAX_DIGITS + 1);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] IDLE_CNT = CNT_W'(CLKS_PER_BIT);
  localparam logic [DIG_W-1:0] DIG_MAX  = DIG_W'(MAX_DIGITS);

  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;

  localparam logic [1:0] DEC_EMPTY    = 2'd0;
  localparam logic [1:0] DEC_DIGITS   = 2'd1;
  localparam logic [1:0] DEC_DISCARD  = 2'd2;

  // Input synchronizer; both stages reset to the idle level
  logic [1:0] sync_reg;
  logic       rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  assign rx_s = sync_reg[1];

  // Receiver state
  logic [2:0]       rx_state_reg,  rx_state_next;
  logic [CNT_W-1:0] cnt_reg,       cnt_next;
  logic [2:0]       bit_idx_reg,   bit_idx_next;
  logic [7:0]       shreg_reg,     shreg_next;
  logic [7:0]       rx_data_reg,   rx_data_next;
  logic             rx_valid_reg,  rx_valid_next;
  logic             frame_err_reg, frame_err_next;

  always_comb begin
    rx_state_next  = rx_state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shreg_next     = shreg_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;

    case (rx_state_reg)
      ST_WAIT_IDLE: begin
        // A high run of exactly one bit period can be a data bit inside a
        // frame, so the line must still be high after a full bit period.
        if (!rx_s) begin
          cnt_next = '0;
        end else if (cnt_reg == IDLE_CNT) begin
          rx_state_next = ST_IDLE;
          cnt_next      = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_IDLE: begin
        if (!rx_s) begin
          rx_state_next = ST_START;
          cnt_next      = '0;
        end
      end

      ST_START: begin
        if (cnt_reg == HALF_M1) begin
          cnt_next = '0;
          if (rx_s) begin
            rx_state_next = ST_IDLE;
          end else begin
            rx_state_next = ST_DATA;
            bit_idx_next  = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_reg == BIT_M1) begin
          cnt_next     = '0;
          shreg_next   = {rx_s, shreg_reg[7:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) begin
            rx_state_next = ST_STOP;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_STOP: begin
        // Sampling mid stop bit lets the next start edge be caught in IDLE
        if (cnt_reg == BIT_M1) begin
          cnt_next = '0;
          if (rx_s) begin
            rx_data_next  = shreg_reg;
            rx_valid_next = 1'b1;
            rx_state_next = ST_IDLE;
          end else begin
            frame_err_next = 1'b1;
            rx_state_next  = ST_WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        rx_state_next = ST_WAIT_IDLE;
        cnt_next      = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg  <= ST_WAIT_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shreg_reg     <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_state_reg  <= rx_state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shreg_reg     <= shreg_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Command decoder, driven by the registered byte/error pulses
  logic [1:0]       dec_state_reg, dec_state_next;
  logic [9:0]       acc_reg,       acc_next;
  logic [DIG_W-1:0] dcnt_reg,      dcnt_next;
  logic [9:0]       cmd_value_reg, cmd_value_next;
  logic             cmd_valid_reg, cmd_valid_next;
  logic             cmd_err_reg,   cmd_err_next;
  logic             is_digit;
  logic             is_term;
  logic [9:0]       acc_mac;

  assign is_digit = (rx_data_reg >= 8'h30) && (rx_data_reg <= 8'h39);
  assign is_term  = (rx_data_reg == 8'h0A) || (rx_data_reg == 8'h0D);
  assign acc_mac  = acc_reg * 10'd10 + {6'd0, rx_data_reg[3:0]};

  always_comb begin
    dec_state_next = dec_state_reg;
    acc_next       = acc_reg;
    dcnt_next      = dcnt_reg;
    cmd_value_next = cmd_value_reg;
    cmd_valid_next = 1'b0;
    cmd_err_next   = 1'b0;

    if (frame_err_reg) begin
      if (dec_state_reg != DEC_DISCARD) begin
        cmd_err_next   = 1'b1;
        dec_state_next = DEC_DISCARD;
      end
    end else if (rx_valid_reg) begin
      case (dec_state_reg)
        DEC_EMPTY, DEC_DIGITS: begin
          if (is_digit) begin
            if (dcnt_reg == DIG_MAX) begin
              cmd_err_next   = 1'b1;
              dec_state_next = DEC_DISCARD;
            end else begin
              acc_next       = acc_mac;
              dcnt_next      = dcnt_reg + 1'b1;
              dec_state_next = DEC_DIGITS;
            end
          end else if (is_term) begin
            // A terminator with no digits (e.g. the LF of CRLF) is ignored
            if (dec_state_reg == DEC_DIGITS) begin
              cmd_value_next = acc_reg;
              cmd_valid_next = 1'b1;
              acc_next       = '0;
              dcnt_next      = '0;
              dec_state_next = DEC_EMPTY;
            end
          end else begin
            cmd_err_next   = 1'b1;
            dec_state_next = DEC_DISCARD;
          end
        end

        DEC_DISCARD: begin
          if (is_term) begin
            acc_next       = '0;
            dcnt_next      = '0;
            dec_state_next = DEC_EMPTY;
          end
        end

        default: begin
          acc_next       = '0;
          dcnt_next      = '0;
          dec_state_next = DEC_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_state_reg <= DEC_EMPTY;
      acc_reg       <= '0;
      dcnt_reg      <= '0;
      cmd_value_reg <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_err_reg   <= 1'b0;
    end else begin
      dec_state_reg <= dec_state_next;
      acc_reg       <= acc_next;
      dcnt_reg      <= dcnt_next;
      cmd_value_reg <= cmd_value_next;
      cmd_valid_reg <= cmd_valid_next;
      cmd_err_reg   <= cmd_err_next;
    end
  end

  assign bus.rx_data   = rx_data_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.cmd_value = cmd_value_reg;
  assign bus.cmd_valid = cmd_valid_reg;
  assign bus.cmd_err   = cmd_err_reg;
  assign bus.busy      = (rx_state_reg == ST_START) ||
                         (rx_state_reg == ST_DATA)  ||
                         (rx_state_reg == ST_STOP);
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: serial frames in, bytes and decoded
// commands checked against queued expectations.
`timescale 1ns/1ps
module tb_uart_cmd_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // negedge of the start-bit drive to negedge where rx_valid is seen
  localparam int LAT  = HALF + 9 * CPB + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_cmd_rx_if bus_if ();

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .MAX_DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_rx[$];
  int         exp_cmd[$];

  int n_rx_valid  = 0;
  int n_frame_err = 0;
  int n_cmd_valid = 0;
  int n_cmd_err   = 0;
  int busy_cycles = 0;

  int cyc          = 0;
  int start_cyc    = 0;
  int last_rxv_cyc = 0;

  logic       rst_at_edge    = 1'b1;
  logic       prev_rxv       = 1'b0;
  logic       prev_ferr      = 1'b0;
  logic [9:0] prev_cmd_value = '0;
  logic [7:0] last_byte      = 8'h00;

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = rst;
  end

  // Monitor: pops the scoreboard on each output pulse
  always @(negedge clk) begin
    logic [7:0] eb;
    int         ec;
    if (bus_if.busy) busy_cycles++;

    if (bus_if.rx_valid) begin
      n_rx_valid++;
      last_rxv_cyc = cyc;
      n_checks++;
      if (exp_rx.size() == 0) begin
        n_fail++;
        $display("FAIL rx_byte: got unexpected rx_valid with 0x%02h, required no byte", bus_if.rx_data);
      end else begin
        eb = exp_rx.pop_front();
        if (bus_if.rx_data !== eb) begin
          n_fail++;
          $display("FAIL rx_byte: got 0x%02h, required 0x%02h", bus_if.rx_data, eb);
        end else begin
          $display("[%0t] rx byte 0x%02h", $time, bus_if.rx_data);
        end
      end
    end

    if (bus_if.frame_err) begin
      n_frame_err++;
      $display("[%0t] frame error", $time);
    end

    if (bus_if.cmd_valid) begin
      n_cmd_valid++;
      n_checks++;
      if (!prev_rxv || bus_if.rx_valid || bus_if.cmd_err) begin
        n_fail++;
        $display("FAIL cmd_valid_timing: got prev_rx_valid=%0b rx_valid=%0b cmd_err=%0b, required 1 0 0",
                 prev_rxv, bus_if.rx_valid, bus_if.cmd_err);
      end
      n_checks++;
      if (exp_cmd.size() == 0) begin
        n_fail++;
        $display("FAIL cmd_value: got unexpected cmd_valid with %0d, required none", bus_if.cmd_value);
      end else begin
        ec = exp_cmd.pop_front();
        if (bus_if.cmd_value !== 10'(ec)) begin
          n_fail++;
          $display("FAIL cmd_value: got %0d, required %0d", bus_if.cmd_value, ec);
        end else begin
          $display("[%0t] command %0d", $time, bus_if.cmd_value);
        end
      end
    end else if (!rst_at_edge) begin
      n_checks++;
      if (bus_if.cmd_value !== prev_cmd_value) begin
        n_fail++;
        $display("FAIL cmd_value_hold: got %0d without cmd_valid, required %0d", bus_if.cmd_value, prev_cmd_value);
      end
    end

    if (bus_if.cmd_err) begin
      n_cmd_err++;
      n_checks++;
      if (!(prev_rxv || prev_ferr)) begin
        n_fail++;
        $display("FAIL cmd_err_timing: got cmd_err with no rx_valid/frame_err 1 cycle earlier, required one");
      end else begin
        $display("[%0t] command error", $time);
      end
    end

    prev_rxv       = bus_if.rx_valid;
    prev_ferr      = bus_if.frame_err;
    prev_cmd_value = bus_if.cmd_value;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test within 400 us, required completion");
    $fatal(1, "watchdog expired");
  end

  // Called on a negedge; returns on the negedge ending the stop bit
  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_rx.push_back(b);
      last_byte = b;
    end
    start_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({bus_if.rx_data, bus_if.cmd_value} !== 18'd0) begin
      n_fail++;
      $display("FAIL %s_data: got rx_data=0x%02h cmd_value=%0d, required 0 0", tag, bus_if.rx_data, bus_if.cmd_value);
    end
    n_checks++;
    if ({bus_if.rx_valid, bus_if.frame_err, bus_if.cmd_valid, bus_if.cmd_err, bus_if.busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s_flags: got rv/fe/cv/ce/busy=%0b%0b%0b%0b%0b, required 00000", tag,
               bus_if.rx_valid, bus_if.frame_err, bus_if.cmd_valid, bus_if.cmd_err, bus_if.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int rv0 = n_rx_valid, cv0 = n_cmd_valid, ce0 = n_cmd_err;
    exp_cmd.push_back(123);
    send_str("123\n");
    n_checks++;
    if (n_rx_valid - rv0 != 4) begin
      n_fail++; $display("FAIL line_rx_count: got %0d, required 4", n_rx_valid - rv0);
    end
    n_checks++;
    if (n_cmd_valid - cv0 != 1) begin
      n_fail++; $display("FAIL line_cmd_count: got %0d, required 1", n_cmd_valid - cv0);
    end
    n_checks++;
    if (n_cmd_err != ce0) begin
      n_fail++; $display("FAIL line_cmd_err: got %0d, required 0", n_cmd_err - ce0);
    end
    n_checks++;
    if (last_rxv_cyc - start_cyc != LAT) begin
      n_fail++; $display("FAIL rx_latency: got %0d, required %0d", last_rxv_cyc - start_cyc, LAT);
    end
    n_checks++;
    if (bus_if.cmd_value !== 10'd123) begin
      n_fail++; $display("FAIL line_value: got %0d, required 123", bus_if.cmd_value);
    end
  endtask

  task automatic test_false_start();
    int rv0 = n_rx_valid, fe0 = n_frame_err, cv0 = n_cmd_valid, b0 = busy_cycles;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++;
    if (busy_cycles - b0 != HALF) begin
      n_fail++; $display("FAIL glitch_busy_len: got %0d, required %0d", busy_cycles - b0, HALF);
    end
    n_checks++;
    if (bus_if.busy !== 1'b0) begin
      n_fail++; $display("FAIL glitch_busy_end: got %0b, required 0", bus_if.busy);
    end
    n_checks++;
    if (n_rx_valid != rv0 || n_frame_err != fe0) begin
      n_fail++; $display("FAIL glitch_output: got rx_valid=%0d frame_err=%0d, required 0 0",
                         n_rx_valid - rv0, n_frame_err - fe0);
    end
    exp_cmd.push_back(7);
    send_str("7\r\n");
    n_checks++;
    if (n_cmd_valid - cv0 != 1 || bus_if.cmd_value !== 10'd7) begin
      n_fail++; $display("FAIL crlf_cmd: got count=%0d value=%0d, required 1 7", n_cmd_valid - cv0, bus_if.cmd_value);
    end
  endtask

  task automatic test_frame_err();
    int rv0 = n_rx_valid, fe0 = n_frame_err, cv0 = n_cmd_valid, ce0 = n_cmd_err;
    logic [7:0] held = last_byte;
    send_byte(8'h35, 1'b0);
    n_checks++;
    if (n_frame_err - fe0 != 1 || n_rx_valid != rv0) begin
      n_fail++; $display("FAIL ferr_pulse: got frame_err=%0d rx_valid=%0d, required 1 0",
                         n_frame_err - fe0, n_rx_valid - rv0);
    end
    n_checks++;
    if (bus_if.rx_data !== held) begin
      n_fail++; $display("FAIL ferr_rx_data: got 0x%02h, required 0x%02h", bus_if.rx_data, held);
    end
    n_checks++;
    if (n_cmd_err - ce0 != 1) begin
      n_fail++; $display("FAIL ferr_cmd_err: got %0d, required 1", n_cmd_err - ce0);
    end
    repeat (40) @(negedge clk);
    exp_cmd.push_back(42);
    send_str("\n42\n");
    n_checks++;
    if (n_cmd_valid - cv0 != 1 || n_cmd_err - ce0 != 1 || bus_if.cmd_value !== 10'd42) begin
      n_fail++; $display("FAIL ferr_recover: got valid=%0d err=%0d value=%0d, required 1 1 42",
                         n_cmd_valid - cv0, n_cmd_err - ce0, bus_if.cmd_value);
    end
  endtask

  task automatic test_bad_commands();
    int cv0 = n_cmd_valid, ce0 = n_cmd_err;
    send_str("1234\n");
    n_checks++;
    if (n_cmd_err - ce0 != 1 || n_cmd_valid != cv0 || bus_if.cmd_value !== 10'd42) begin
      n_fail++; $display("FAIL overflow: got err=%0d valid=%0d value=%0d, required 1 0 42",
                         n_cmd_err - ce0, n_cmd_valid - cv0, bus_if.cmd_value);
    end
    send_str("4a2\n");
    n_checks++;
    if (n_cmd_err - ce0 != 2 || n_cmd_valid != cv0) begin
      n_fail++; $display("FAIL bad_char: got err=%0d valid=%0d, required 2 0", n_cmd_err - ce0, n_cmd_valid - cv0);
    end
    exp_cmd.push_back(999);
    send_str("999\n");
    n_checks++;
    if (n_cmd_valid - cv0 != 1 || n_cmd_err - ce0 != 2 || bus_if.cmd_value !== 10'd999) begin
      n_fail++; $display("FAIL max_value: got valid=%0d err=%0d value=%0d, required 1 2 999",
                         n_cmd_valid - cv0, n_cmd_err - ce0, bus_if.cmd_value);
    end
  endtask

  task automatic test_terminators();
    int rv0 = n_rx_valid, cv0 = n_cmd_valid, ce0 = n_cmd_err;
    send_str("\n\r\n");
    n_checks++;
    if (n_rx_valid - rv0 != 3 || n_cmd_valid != cv0 || n_cmd_err != ce0) begin
      n_fail++; $display("FAIL empty_lines: got rx=%0d valid=%0d err=%0d, required 3 0 0",
                         n_rx_valid - rv0, n_cmd_valid - cv0, n_cmd_err - ce0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b = 8'h55;
    int rv0 = n_rx_valid, fe0 = n_frame_err, cv0;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midframe_reset");
    rst = 1'b0;
    repeat (CPB - HALF - 1) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB + 40) @(negedge clk);
    n_checks++;
    if (n_rx_valid != rv0 || n_frame_err != fe0) begin
      n_fail++; $display("FAIL midframe_remainder: got rx_valid=%0d frame_err=%0d, required 0 0",
                         n_rx_valid - rv0, n_frame_err - fe0);
    end
    cv0 = n_cmd_valid;
    exp_cmd.push_back(5);
    send_str("5\n");
    n_checks++;
    if (n_cmd_valid - cv0 != 1 || bus_if.cmd_value !== 10'd5) begin
      n_fail++; $display("FAIL midframe_recover: got valid=%0d value=%0d, required 1 5",
                         n_cmd_valid - cv0, bus_if.cmd_value);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_bad_commands();
    test_terminators();
    test_reset_midframe();
    repeat (10) @(negedge clk);
    n_checks++;
    if (exp_rx.size() != 0 || exp_cmd.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d bytes %0d commands pending, required 0 0",
                         exp_rx.size(), exp_cmd.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
